div_ctrl: RTL

Multi-cycle divide sequencer for the MIPS core's execute stage. It accepts one divide request, runs a radix-2 restoring division over WIDTH iterations and applies sign fix-up. It drives a stall to the pipeline registers until the quotient and remainder are ready, and it aborts cleanly on a pipeline flush.

---
 rtl/div_ctrl_if.sv | 25 ++
 rtl/div_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the execute stage and the divide sequencer.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, a, b, cancel,
    input  stall, busy, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output stall, busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer with sign fix-up, stall and flush.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_stall;

  always_comb begin
    w_a_neg = bus.signed_div & bus.a[WIDTH-1];
    w_b_neg = bus.signed_div & bus.b[WIDTH-1];
    w_abs_a = w_a_neg ? -bus.a : bus.a;
    w_abs_b = w_b_neg ? -bus.b : bus.b;
    // The dividend register doubles as the quotient shift register.
    w_shift = {r_rem, r_dvd[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_div};
    w_stall = (r_busy & ~r_done) | (bus.start & ~bus.cancel & (r_state == S_IDLE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_div     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.cancel) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_busy <= 1'b1;
              if (bus.b == '0) begin
                r_quot    <= '1;
                r_rem_out <= bus.a;
                r_done    <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_dvd    <= w_abs_a;
                r_div    <= w_abs_b;
                r_rem    <= '0;
                r_sign_q <= w_a_neg ^ w_b_neg;
                r_sign_r <= w_a_neg;
                r_cnt    <= CNT_W'(WIDTH);
                r_state  <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_quot    <= r_sign_q ? -r_dvd : r_dvd;
            r_rem_out <= r_sign_r ? -r_rem : r_rem;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.stall     = w_stall;
    bus.busy      = r_busy;
    bus.done      = r_done;
    bus.quotient  = r_quot;
    bus.remainder = r_rem_out;
  end
endmodule
